jt89_wr_seq: RTL

CPU write sequencer and register file for the JT89 PSG. It accepts byte writes from the host bus, decodes SN76489 latch/data bytes, and holds the three tone periods, four attenuations and the noise control. It emulates the chip's READY handshake by refusing further writes for a programmable number of `clk_en` pulses, and issues the one-clock `noise_clr` that reloads the noise LFSR whenever the noise control register is written. It sits between the bus glue and the tone/noise channel blocks.

---
 rtl/jt89_wr_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/jt89_wr_seq.sv
// JT89 host write sequencer: SN76489 latch/data decode, register file,
// READY busy emulation and noise LFSR reload strobe.
module jt89_wr_seq #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [7:0] din,
  input  logic       wr_n,
  output logic       ready,
  output logic       ovf,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_clr
);

  localparam int CW = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES);

  logic          wr_d;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    lat;
  logic [2:0]    sel;
  logic          ev, acc;

  // armed holds off events on the first edge after reset release
  assign ev  = ~wr_n & wr_d & armed;
  assign acc = ev & ready;
  assign sel = din[7] ? din[6:4] : lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_d      <= 1'b1;
      armed     <= 1'b0;
      ovf       <= 1'b0;
      noise_clr <= 1'b0;
    end else begin
      wr_d      <= wr_n;
      armed     <= 1'b1;
      ovf       <= ev & ~ready;
      noise_clr <= acc & (sel == 3'b110);
    end
  end

  // counter only loads from zero, so load and decrement never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ready <= 1'b1;
    end else if (acc && BUSY_CYCLES > 0) begin
      cnt   <= BUSY_LOAD;
      ready <= 1'b0;
    end else if (clk_en && cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat   <= 3'b000;
      tone0 <= '0;
      tone1 <= '0;
      tone2 <= '0;
      vol0  <= 4'hF;
      vol1  <= 4'hF;
      vol2  <= 4'hF;
      vol3  <= 4'hF;
      ctrl3 <= '0;
    end else if (acc) begin
      if (din[7]) lat <= din[6:4];
      case (sel)
        3'b000: tone0 <= din[7] ? {tone0[9:4], din[3:0]} : {din[5:0], tone0[3:0]};
        3'b010: tone1 <= din[7] ? {tone1[9:4], din[3:0]} : {din[5:0], tone1[3:0]};
        3'b100: tone2 <= din[7] ? {tone2[9:4], din[3:0]} : {din[5:0], tone2[3:0]};
        3'b001: vol0  <= din[3:0];
        3'b011: vol1  <= din[3:0];
        3'b101: vol2  <= din[3:0];
        3'b110: ctrl3 <= din[2:0];
        default: vol3 <= din[3:0];
      endcase
    end
  end

endmodule
